// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op codes, opcode constants, immediate extraction and the
// decoded-instruction record handed from decode to execute.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } id_out_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
// Define ID_WB_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] data;
    data = '0;
    if (addr != 5'd0) begin
      data = regs_q[addr];
`ifdef ID_WB_BYPASS_EN
      if (we_i && (waddr_i == addr)) begin
        data = wdata_i;
      end
`endif
    end
    return data;
  endfunction

  always_comb begin
    rdata1_o = read_port(raddr1_i);
    rdata2_o = read_port(raddr2_i);
  end

endmodule

// File: rtl/id_stage.sv
// Decode/operand-issue stage: decodes RV32I ALU instructions and registers operands for execute.
// ID_WB_BYPASS_EN (in reg_file) selects write-through forwarding for same-cycle reads.
module id_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data;
  id_out_t     dec;
  id_out_t     data_d, data_q;
  logic        valid_d, valid_q;
  logic        load;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  reg_file u_reg_file (
    .clk_i    (clk),
    .rst_i    (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.rd      = rd;
    dec.rd_we   = (rd != 5'd0);
    unique case (opcode)
      OPC_OP: begin
        dec.op1    = rs1_data;
        dec.op2    = rs2_data;
        dec.alu_op = {in_instr[30], funct3};
      end
      OPC_OPIMM: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i(in_instr);
        // imm[10] is only an opcode bit for right shifts; ADDI must never become SUB.
        dec.alu_op = (funct3 == 3'b101) ? {in_instr[30], funct3} : {1'b0, funct3};
      end
      OPC_LUI: begin
        dec.op2 = imm_u(in_instr);
      end
      OPC_AUIPC: begin
        dec.op1 = in_pc;
        dec.op2 = imm_u(in_instr);
      end
      default: begin
        dec.rd      = '0;
        dec.rd_we   = 1'b0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_comb begin
    data_d  = load ? dec : data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q        <= 1'b0;
      data_q         <= '0;
      data_q.alu_op  <= ALU_ADD;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_op1     = data_q.op1;
  assign out_op2     = data_q.op2;
  assign out_alu_op  = data_q.alu_op;
  assign out_rd      = data_q.rd;
  assign out_rd_we   = data_q.rd_we;
  assign out_illegal = data_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage with a behavioural reference model and directed literal checks.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_op1, out_op2, wb_data;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd, wb_rd;
  logic        out_rd_we, out_illegal, wb_we;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_op1, m_op2;
  logic [3:0]  m_alu;
  logic [4:0]  m_rd;
  logic        m_we, m_ill;

  always #5 clk = ~clk;

  id_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op1    (out_op1),
    .out_op2    (out_op2),
    .out_alu_op (out_alu_op),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .out_illegal(out_illegal),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_alu = 0; m_rd = 0; m_we = 0; m_ill = 0;
  endtask

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && int'(wb_rd) == r) return wb_data;
`endif
    return m_regs[r];
  endfunction

  // Computes next model state from the inputs present before the coming edge.
  logic        n_valid;
  logic [31:0] n_op1, n_op2;
  logic [3:0]  n_alu;
  logic [4:0]  n_rd;
  logic        n_we, n_ill;

  task automatic model_next();
    int opc, rdv, f3, f7b5, rs1v, rs2v;
    bit ready, take;
    opc  = int'(in_instr & 32'h7F);
    rdv  = int'((in_instr >> 7) & 32'h1F);
    f3   = int'((in_instr >> 12) & 32'h7);
    rs1v = int'((in_instr >> 15) & 32'h1F);
    rs2v = int'((in_instr >> 20) & 32'h1F);
    f7b5 = int'((in_instr >> 30) & 32'h1);
    ready = !m_valid || out_ready;
    take  = in_valid && ready && !flush;
    n_valid = flush ? 1'b0 : (take ? 1'b1 : (out_ready ? 1'b0 : m_valid));
    {n_op1, n_op2, n_alu, n_rd, n_we, n_ill} = {m_op1, m_op2, m_alu, m_rd, m_we, m_ill};
    if (take) begin
      n_op1 = 0; n_op2 = 0; n_alu = 0; n_rd = 5'(rdv); n_we = (rdv != 0); n_ill = 0;
      case (opc)
        'h33: begin n_op1 = m_read(rs1v); n_op2 = m_read(rs2v); n_alu = 4'(f7b5 * 8 + f3); end
        'h13: begin
          n_op1 = m_read(rs1v);
          n_op2 = $signed(in_instr) >>> 20;
          n_alu = (f3 == 5) ? 4'(f7b5 * 8 + f3) : 4'(f3);
        end
        'h37: n_op2 = in_instr & 32'hFFFFF000;
        'h17: begin n_op1 = in_pc; n_op2 = in_instr & 32'hFFFFF000; end
        default: begin n_rd = 0; n_we = 0; n_ill = 1; end
      endcase
    end
  endtask

  task automatic compare();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_op1", out_op1, m_op1);
      check("out_op2", out_op2, m_op2);
      check("out_alu_op", 32'(out_alu_op), 32'(m_alu));
      check("out_rd", 32'(out_rd), 32'(m_rd));
      check("out_rd_we", 32'(out_rd_we), 32'(m_we));
      check("out_illegal", 32'(out_illegal), 32'(m_ill));
    end
  endtask

  // Inputs are applied just after an edge; checks in_ready, advances one edge, compares outputs.
  task automatic cycle();
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    model_next();
    @(posedge clk);
    #1;
    if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    {m_valid, m_op1, m_op2, m_alu, m_rd, m_we, m_ill} =
      {n_valid, n_op1, n_op2, n_alu, n_rd, n_we, n_ill};
    compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_op1"}, out_op1, 0);
    check({tag, "_op2"}, out_op2, 0);
    check({tag, "_alu"}, 32'(out_alu_op), 0);
    check({tag, "_rd"}, 32'(out_rd), 0);
    check({tag, "_we"}, 32'(out_rd_we), 0);
    check({tag, "_ill"}, 32'(out_illegal), 0);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1; in_instr = instr; in_pc = pc;
    cycle();
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1; wb_rd = r; wb_data = d; in_valid = 0;
    cycle();
    wb_we = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 0;

    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    issue(32'h402081B3, 0);  // sub x3,x1,x2
    check("sub_op1", out_op1, 5);
    check("sub_op2", out_op2, 3);
    check("sub_alu", 32'(out_alu_op), 32'b1000);
    check("sub_rd", 32'(out_rd), 3);
    check("sub_we", 32'(out_rd_we), 1);
    issue(32'hFFF00213, 0);  // addi x4,x0,-1
    check("addi_op1", out_op1, 0);
    check("addi_op2", out_op2, 32'hFFFFFFFF);
    check("addi_alu", 32'(out_alu_op), 0);
    issue(32'h4020D293, 0);  // srai x5,x1,2
    check("srai_alu", 32'(out_alu_op), 32'b1101);
    check("srai_op2", out_op2, 32'h402);
    issue(32'h12345317, 32'h100);  // auipc x6,0x12345
    check("auipc_op1", out_op1, 32'h100);
    check("auipc_op2", out_op2, 32'h12345000);
    check("auipc_alu", 32'(out_alu_op), 0);
    issue(32'h0000007F, 0);
    check("ill_flag", 32'(out_illegal), 1);
    check("ill_we", 32'(out_rd_we), 0);
    check("ill_op1", out_op1, 0);

    // Same-cycle writeback of x1 while reading it: add x7,x1,x0
    wb_we = 1; wb_rd = 5'd1; wb_data = 32'hAA;
    issue(32'h000083B3, 0);
    wb_we = 0;
`ifdef ID_WB_BYPASS_EN
    check("byp_op1", out_op1, 32'hAA);
`else
    check("byp_op1", out_op1, 32'd5);
`endif
    issue(32'h000083B3, 0);
    check("after_wb_op1", out_op1, 32'hAA);

    wb(5'd0, 32'hDEAD);
    issue(32'h00000433, 0);  // add x8,x0,x0
    check("x0_op1", out_op1, 0);
    check("x0_op2", out_op2, 0);

    // Stall three cycles with x8 result held, then drain back to back
    out_ready = 0; in_valid = 1; in_instr = 32'h402084B3;  // sub x9,x1,x2
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", 32'(in_ready), 0);
      check("stall_rd", 32'(out_rd), 8);
    end
    out_ready = 1;
    cycle();
    check("drain_rd9", 32'(out_rd), 9);
    in_instr = 32'h40208533;  // sub x10
    cycle();
    check("drain_rd10", 32'(out_rd), 10);
    in_instr = 32'h402085B3;  // sub x11
    cycle();
    check("drain_rd11", 32'(out_rd), 11);

    // Flush with held instruction and a new offer, stalled and with out_ready high
    out_ready = 0; flush = 1;
    cycle();
    check("flush_valid", 32'(out_valid), 0);
    issue(32'h402081B3, 0);
    flush = 0;
    cycle();
    out_ready = 1; flush = 1;
    cycle();
    check("flush_rdy_valid", 32'(out_valid), 0);
    flush = 0;

    // Asynchronous reset in the middle of a stall
    out_ready = 0;
    issue(32'h402081B3, 0);
    cycle();
    #2;
    reset = 1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 0; out_ready = 1; in_valid = 0;

    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 4);
      in_instr = $urandom;
      case (sel)
        0: in_instr[6:0] = 7'b0110011;
        1: in_instr[6:0] = 7'b0010011;
        2: in_instr[6:0] = 7'b0110111;
        3: in_instr[6:0] = 7'b0010111;
        default: ;
      endcase
      in_pc     = $urandom;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      wb_we     = $urandom_range(0, 1);
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
